// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the hardwired control sequencer: step states, opcodes, ALU codes, IR fields.
// Pure declarations and decode helpers; no timing or flow-control behaviour of its own.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    T0, T1, T2, T3, T4, T5, T6, T7, HALTED
  } state_t;

  // Instruction classes that select the execute-step sequence.
  typedef enum logic [2:0] {
    CLS_NOP, CLS_R, CLS_I, CLS_MD, CLS_LD, CLS_ST, CLS_HALT
  } cls_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_AND = 5'b00101;
  localparam logic [4:0] ALU_OR  = 5'b00110;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  localparam logic [1:0] READ_MEM = 2'b01;
  localparam logic [1:0] READ_BUS = 2'b00;

  // One registered control word; the GPR strobes travel as field+valid and are expanded after the register.
  typedef struct packed {
    logic       gpr_vld;
    logic [3:0] gpr_sel;
    logic       e_vld;
    logic [3:0] e_sel;
    logic       en_pc;
    logic       en_ir;
    logic       en_hi;
    logic       en_lo;
    logic       en_zhi;
    logic       en_zlo;
    logic       en_mar;
    logic       en_mdr;
    logic       en_y;
    logic       sel_pc;
    logic       sel_hi;
    logic       sel_lo;
    logic       sel_zhi;
    logic       sel_zlo;
    logic       sel_mdr;
    logic       sel_c;
    logic       inc_pc;
    logic [1:0] read;
    logic       mem_write;
    logic [4:0] alu_op;
  } ctrl_t;

  function automatic cls_t op_class(input logic [4:0] op);
    cls_t c;
    c = CLS_NOP;
    if (op >= OP_ADD && op <= OP_ROR) begin
      c = CLS_R;
    end else begin
      case (op)
        OP_ADDI, OP_ANDI, OP_ORI: c = CLS_I;
        OP_MUL, OP_DIV:           c = CLS_MD;
        OP_LD:                    c = CLS_LD;
        OP_ST:                    c = CLS_ST;
        OP_HALT:                  c = CLS_HALT;
        default:                  c = CLS_NOP;
      endcase
    end
    return c;
  endfunction

  // Immediate forms reuse the register-form ALU operation.
  function automatic logic [4:0] imm_alu(input logic [4:0] op);
    logic [4:0] a;
    case (op)
      OP_ANDI: a = ALU_AND;
      OP_ORI:  a = ALU_OR;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// 4-bit register field to 16-bit one-hot strobe, all zero when not enabled.
// Combinational, zero latency; no flow control.
module reg_field_decoder (
  input  logic [3:0]  field,
  input  logic        en,
  output logic [15:0] onehot
);

  assign onehot = en ? (16'd1 << field) : 16'd0;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: fetch T0-T2, class-specific execute T3-T7, memory wait with timeout.
// Strobes are a registered decode of the current step (one cycle behind the state); memory stalls hold the step.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [3:0] MEM_TIMEOUT = 4'd15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  input  logic        stop,
  output logic [15:0] enable_GPR,
  output logic [15:0] select_E,
  output logic        enable_PC,
  output logic        enable_IR,
  output logic        enable_HI,
  output logic        enable_LO,
  output logic        enable_ZHI,
  output logic        enable_ZLO,
  output logic        enable_MAR,
  output logic        enable_MDR,
  output logic        enable_Y,
  output logic        select_PC,
  output logic        select_HI,
  output logic        select_LO,
  output logic        select_ZHI,
  output logic        select_ZLO,
  output logic        select_MDR,
  output logic        select_C,
  output logic        IncPC,
  output logic [1:0]  Read,
  output logic        mem_write,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        fault
);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       run_q, fault_q;
  ctrl_t      ctrl_q, ctrl_d;
  logic       mem_wait, last_step, timeout;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  cls_t       cls;
  logic       unused_ir_bits;

  assign op  = ir[OP_MSB:OP_LSB];
  assign ra  = ir[RA_MSB:RA_LSB];
  assign rb  = ir[RB_MSB:RB_LSB];
  assign rc  = ir[RC_MSB:RC_LSB];
  assign cls = op_class(op);
  assign unused_ir_bits = ^ir[RC_LSB-1:0];

  always_comb begin
    state_d   = state_q;
    wait_d    = 4'd0;
    mem_wait  = 1'b0;
    last_step = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      T0: state_d = T1;
      T1: begin
        mem_wait = 1'b1;
        if (mem_ready) state_d = T2;
      end
      T2: begin
        case (cls)
          CLS_NOP:  begin last_step = 1'b1; state_d = T0; end
          CLS_HALT: state_d = HALTED;
          default:  state_d = T3;
        endcase
      end
      T3: state_d = T4;
      T4: state_d = T5;
      T5: begin
        if (cls == CLS_R || cls == CLS_I) begin
          last_step = 1'b1;
          state_d   = T0;
        end else begin
          state_d = T6;
        end
      end
      T6: begin
        if (cls == CLS_MD) begin
          last_step = 1'b1;
          state_d   = T0;
        end else if (cls == CLS_LD) begin
          mem_wait = 1'b1;
          if (mem_ready) state_d = T7;
        end else begin
          state_d = T7;
        end
      end
      T7: begin
        if (cls == CLS_ST) begin
          mem_wait = 1'b1;
          if (mem_ready) begin
            last_step = 1'b1;
            state_d   = T0;
          end
        end else begin
          last_step = 1'b1;
          state_d   = T0;
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = T0;
    endcase

    // A ready memory always wins; only a genuinely stalled cycle advances the counter.
    if (mem_wait && !mem_ready) begin
      if (wait_q == MEM_TIMEOUT - 4'd1) begin
        timeout = 1'b1;
        state_d = HALTED;
      end else begin
        wait_d = wait_q + 4'd1;
      end
    end

    if (last_step && stop) state_d = HALTED;
  end

  always_comb begin
    ctrl_d = '0;
    case (state_q)
      T0: begin
        ctrl_d.sel_pc = 1'b1;
        ctrl_d.en_mar = 1'b1;
        ctrl_d.inc_pc = 1'b1;
      end
      T1: begin
        ctrl_d.read   = READ_MEM;
        ctrl_d.en_mdr = 1'b1;
      end
      T2: begin
        ctrl_d.sel_mdr = 1'b1;
        ctrl_d.en_ir   = 1'b1;
      end
      T3: begin
        if (cls != CLS_NOP && cls != CLS_HALT) begin
          ctrl_d.e_vld = 1'b1;
          ctrl_d.e_sel = (cls == CLS_MD) ? ra : rb;
          ctrl_d.en_y  = 1'b1;
        end
      end
      T4: begin
        case (cls)
          CLS_R: begin
            ctrl_d.e_vld  = 1'b1;
            ctrl_d.e_sel  = rc;
            ctrl_d.alu_op = op;
            ctrl_d.en_zlo = 1'b1;
          end
          CLS_I: begin
            ctrl_d.sel_c  = 1'b1;
            ctrl_d.alu_op = imm_alu(op);
            ctrl_d.en_zlo = 1'b1;
          end
          CLS_MD: begin
            ctrl_d.e_vld  = 1'b1;
            ctrl_d.e_sel  = rb;
            ctrl_d.alu_op = op;
            ctrl_d.en_zhi = 1'b1;
            ctrl_d.en_zlo = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            ctrl_d.sel_c  = 1'b1;
            ctrl_d.alu_op = ALU_ADD;
            ctrl_d.en_zlo = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          CLS_R, CLS_I: begin
            ctrl_d.sel_zlo = 1'b1;
            ctrl_d.gpr_vld = 1'b1;
            ctrl_d.gpr_sel = ra;
          end
          CLS_MD: begin
            ctrl_d.sel_zlo = 1'b1;
            ctrl_d.en_lo   = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            ctrl_d.sel_zlo = 1'b1;
            ctrl_d.en_mar  = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        case (cls)
          CLS_MD: begin
            ctrl_d.sel_zhi = 1'b1;
            ctrl_d.en_hi   = 1'b1;
          end
          CLS_LD: begin
            ctrl_d.read   = READ_MEM;
            ctrl_d.en_mdr = 1'b1;
          end
          CLS_ST: begin
            ctrl_d.e_vld  = 1'b1;
            ctrl_d.e_sel  = ra;
            ctrl_d.read   = READ_BUS;
            ctrl_d.en_mdr = 1'b1;
          end
          default: ;
        endcase
      end
      T7: begin
        if (cls == CLS_LD) begin
          ctrl_d.sel_mdr = 1'b1;
          ctrl_d.gpr_vld = 1'b1;
          ctrl_d.gpr_sel = ra;
        end else if (cls == CLS_ST) begin
          ctrl_d.mem_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= T0;
      wait_q  <= 4'd0;
      run_q   <= 1'b1;
      fault_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      run_q   <= (state_d != HALTED);
      if (timeout) fault_q <= 1'b1;
      // A timeout aborts the access, so the stalled strobes are dropped rather than shown one more cycle.
      ctrl_q  <= timeout ? '0 : ctrl_d;
    end
  end

  reg_field_decoder u_gpr_dec (
    .field  (ctrl_q.gpr_sel),
    .en     (ctrl_q.gpr_vld),
    .onehot (enable_GPR)
  );

  reg_field_decoder u_bus_dec (
    .field  (ctrl_q.e_sel),
    .en     (ctrl_q.e_vld),
    .onehot (select_E)
  );

  assign enable_PC  = ctrl_q.en_pc;
  assign enable_IR  = ctrl_q.en_ir;
  assign enable_HI  = ctrl_q.en_hi;
  assign enable_LO  = ctrl_q.en_lo;
  assign enable_ZHI = ctrl_q.en_zhi;
  assign enable_ZLO = ctrl_q.en_zlo;
  assign enable_MAR = ctrl_q.en_mar;
  assign enable_MDR = ctrl_q.en_mdr;
  assign enable_Y   = ctrl_q.en_y;
  assign select_PC  = ctrl_q.sel_pc;
  assign select_HI  = ctrl_q.sel_hi;
  assign select_LO  = ctrl_q.sel_lo;
  assign select_ZHI = ctrl_q.sel_zhi;
  assign select_ZLO = ctrl_q.sel_zlo;
  assign select_MDR = ctrl_q.sel_mdr;
  assign select_C   = ctrl_q.sel_c;
  assign IncPC      = ctrl_q.inc_pc;
  assign Read       = ctrl_q.read;
  assign mem_write  = ctrl_q.mem_write;
  assign alu_op     = ctrl_q.alu_op;
  assign run        = run_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected control words are queued as each step is driven
// and popped against the registered outputs one cycle later.
module tb_control_sequencer;

  typedef struct packed {
    logic [15:0] gpr;
    logic [15:0] sel_e;
    logic [8:0]  en;   // PC IR HI LO ZHI ZLO MAR MDR Y
    logic [6:0]  sel;  // PC HI LO ZHI ZLO MDR C
    logic        inc;
    logic [1:0]  rd;
    logic        mw;
    logic [4:0]  alu;
    logic        run;
    logic        fault;
  } obs_t;

  localparam logic [8:0] E_Y = 9'h001, E_MDR = 9'h002, E_MAR = 9'h004, E_ZLO = 9'h008, E_ZHI = 9'h010;
  localparam logic [8:0] E_LO = 9'h020, E_HI = 9'h040, E_IR = 9'h080;
  localparam logic [6:0] S_C = 7'h01, S_MDR = 7'h02, S_ZLO = 7'h04, S_ZHI = 7'h08, S_PC = 7'h40;

  localparam logic [31:0] IR_ADD  = 32'h19A2_8000; // add R3,R4,R5
  localparam logic [31:0] IR_NOP  = 32'hF800_0000;
  localparam logic [31:0] IR_LD   = 32'h0130_0000; // ld R2, imm(R6)
  localparam logic [31:0] IR_ST   = 32'h1388_0000; // st R7 -> imm(R1)
  localparam logic [31:0] IR_MUL  = 32'h7890_0000; // mul R1,R2
  localparam logic [31:0] IR_HALT = 32'hD800_0000;

  logic        clk = 1'b0;
  logic        clr, mem_ready, stop;
  logic [31:0] ir;
  logic [15:0] enable_GPR, select_E;
  logic        enable_PC, enable_IR, enable_HI, enable_LO, enable_ZHI, enable_ZLO, enable_MAR, enable_MDR, enable_Y;
  logic        select_PC, select_HI, select_LO, select_ZHI, select_ZLO, select_MDR, select_C;
  logic        IncPC, mem_write, run, fault;
  logic [1:0]  Read;
  logic [4:0]  alu_op;

  obs_t  got;
  obs_t  exp_q[$];
  obs_t  F0, F1, F2, Z, H, FLT;
  int    checks = 0;
  int    errors = 0;
  int    step_no = 0;
  int    gpr_hits = 0;
  string tag = "reset";

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready), .stop(stop),
    .enable_GPR(enable_GPR), .select_E(select_E),
    .enable_PC(enable_PC), .enable_IR(enable_IR), .enable_HI(enable_HI), .enable_LO(enable_LO),
    .enable_ZHI(enable_ZHI), .enable_ZLO(enable_ZLO), .enable_MAR(enable_MAR), .enable_MDR(enable_MDR),
    .enable_Y(enable_Y), .select_PC(select_PC), .select_HI(select_HI), .select_LO(select_LO),
    .select_ZHI(select_ZHI), .select_ZLO(select_ZLO), .select_MDR(select_MDR), .select_C(select_C),
    .IncPC(IncPC), .Read(Read), .mem_write(mem_write), .alu_op(alu_op), .run(run), .fault(fault)
  );

  assign got = {enable_GPR, select_E,
                enable_PC, enable_IR, enable_HI, enable_LO, enable_ZHI, enable_ZLO, enable_MAR, enable_MDR, enable_Y,
                select_PC, select_HI, select_LO, select_ZHI, select_ZLO, select_MDR, select_C,
                IncPC, Read, mem_write, alu_op, run, fault};

  function automatic obs_t mk(input logic [15:0] g, input logic [15:0] e, input logic [8:0] en,
                              input logic [6:0] sel, input logic inc, input logic [1:0] rd,
                              input logic mw, input logic [4:0] alu);
    return {g, e, en, sel, inc, rd, mw, alu, 1'b1, 1'b0};
  endfunction

  task automatic check_obs(input string name, input obs_t obs, input obs_t expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  task automatic check_int(input string name, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", name, obs, expv);
    end
  endtask

  // One clock with the given mem_ready; the popped word is what this step's state should have produced.
  task automatic step(input logic mr);
    obs_t e;
    mem_ready = mr;
    @(posedge clk);
    #1;
    step_no++;
    if (got.gpr != 16'd0) gpr_hits++;
    if (exp_q.size() == 0) begin
      check_int({tag, "_queue_underflow"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_obs($sformatf("%s_step%0d", tag, step_no), got, e);
    end
  endtask

  task automatic do_clr(input string name);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check_obs(name, got, Z);
  endtask

  task automatic begin_test(input string name, input logic [31:0] instr);
    tag = name;
    ir = instr;
    step_no = 0;
    gpr_hits = 0;
  endtask

  initial begin
    obs_t t;
    F0  = mk(16'd0, 16'd0, E_MAR, S_PC, 1'b1, 2'b00, 1'b0, 5'd0);
    F1  = mk(16'd0, 16'd0, E_MDR, 7'd0, 1'b0, 2'b01, 1'b0, 5'd0);
    F2  = mk(16'd0, 16'd0, E_IR, S_MDR, 1'b0, 2'b00, 1'b0, 5'd0);
    Z   = mk(16'd0, 16'd0, 9'd0, 7'd0, 1'b0, 2'b00, 1'b0, 5'd0);
    H   = '0;
    FLT = '0;
    FLT.fault = 1'b1;

    clr = 1'b1; mem_ready = 1'b1; stop = 1'b0; ir = 32'd0;
    @(posedge clk);
    do_clr("reset_state");

    begin_test("add", IR_ADD);
    exp_q.push_back(F0); exp_q.push_back(F1); exp_q.push_back(F2);
    exp_q.push_back(mk(16'd0, 16'h0010, E_Y, 7'd0, 1'b0, 2'b00, 1'b0, 5'd0));
    exp_q.push_back(mk(16'd0, 16'h0020, E_ZLO, 7'd0, 1'b0, 2'b00, 1'b0, 5'b00011));
    exp_q.push_back(mk(16'h0008, 16'd0, 9'd0, S_ZLO, 1'b0, 2'b00, 1'b0, 5'd0));
    repeat (6) step(1'b1);

    begin_test("nop", IR_NOP);
    exp_q.push_back(F0); exp_q.push_back(F1); exp_q.push_back(F2);
    repeat (3) step(1'b1);

    begin_test("ld_wait", IR_LD);
    exp_q.push_back(F0); exp_q.push_back(F1); exp_q.push_back(F2);
    exp_q.push_back(mk(16'd0, 16'h0040, E_Y, 7'd0, 1'b0, 2'b00, 1'b0, 5'd0));
    exp_q.push_back(mk(16'd0, 16'd0, E_ZLO, S_C, 1'b0, 2'b00, 1'b0, 5'b00011));
    exp_q.push_back(mk(16'd0, 16'd0, E_MAR, S_ZLO, 1'b0, 2'b00, 1'b0, 5'd0));
    repeat (4) exp_q.push_back(mk(16'd0, 16'd0, E_MDR, 7'd0, 1'b0, 2'b01, 1'b0, 5'd0));
    exp_q.push_back(mk(16'h0004, 16'd0, 9'd0, S_MDR, 1'b0, 2'b00, 1'b0, 5'd0));
    repeat (6) step(1'b1);
    repeat (3) step(1'b0);
    repeat (2) step(1'b1);
    check_int("ld_gpr_strobe_count", gpr_hits, 1);

    begin_test("st_wait", IR_ST);
    exp_q.push_back(F0); exp_q.push_back(F1); exp_q.push_back(F2);
    exp_q.push_back(mk(16'd0, 16'h0002, E_Y, 7'd0, 1'b0, 2'b00, 1'b0, 5'd0));
    exp_q.push_back(mk(16'd0, 16'd0, E_ZLO, S_C, 1'b0, 2'b00, 1'b0, 5'b00011));
    exp_q.push_back(mk(16'd0, 16'd0, E_MAR, S_ZLO, 1'b0, 2'b00, 1'b0, 5'd0));
    exp_q.push_back(mk(16'd0, 16'h0080, E_MDR, 7'd0, 1'b0, 2'b00, 1'b0, 5'd0));
    repeat (3) exp_q.push_back(mk(16'd0, 16'd0, 9'd0, 7'd0, 1'b0, 2'b00, 1'b1, 5'd0));
    repeat (7) step(1'b1);
    repeat (2) step(1'b0);
    step(1'b1);
    check_int("st_gpr_strobe_count", gpr_hits, 0);

    // stop is raised a step early to show only the final execute step samples it.
    begin_test("mul_stop", IR_MUL);
    exp_q.push_back(F0); exp_q.push_back(F1); exp_q.push_back(F2);
    exp_q.push_back(mk(16'd0, 16'h0002, E_Y, 7'd0, 1'b0, 2'b00, 1'b0, 5'd0));
    exp_q.push_back(mk(16'd0, 16'h0004, E_ZHI | E_ZLO, 7'd0, 1'b0, 2'b00, 1'b0, 5'b01111));
    exp_q.push_back(mk(16'd0, 16'd0, E_LO, S_ZLO, 1'b0, 2'b00, 1'b0, 5'd0));
    t = mk(16'd0, 16'd0, E_HI, S_ZHI, 1'b0, 2'b00, 1'b0, 5'd0);
    t.run = 1'b0;
    exp_q.push_back(t);
    exp_q.push_back(H); exp_q.push_back(H);
    repeat (5) step(1'b1);
    stop = 1'b1;
    repeat (4) step(1'b1);
    stop = 1'b0;
    do_clr("clr_from_halted");

    begin_test("clr_mid_ld", IR_LD);
    exp_q.push_back(F0); exp_q.push_back(F1); exp_q.push_back(F2);
    exp_q.push_back(mk(16'd0, 16'h0040, E_Y, 7'd0, 1'b0, 2'b00, 1'b0, 5'd0));
    exp_q.push_back(mk(16'd0, 16'd0, E_ZLO, S_C, 1'b0, 2'b00, 1'b0, 5'b00011));
    repeat (5) step(1'b1);
    do_clr("clr_in_ld_t5");
    exp_q.push_back(F0);
    step(1'b1);
    do_clr("clr_after_ld_abort");

    begin_test("halt_op", IR_HALT);
    t = F2;
    t.run = 1'b0;
    exp_q.push_back(F0); exp_q.push_back(F1); exp_q.push_back(t); exp_q.push_back(H);
    repeat (4) step(1'b1);
    do_clr("clr_after_halt_op");

    begin_test("fetch_timeout", IR_ADD);
    exp_q.push_back(F0);
    repeat (14) exp_q.push_back(F1);
    exp_q.push_back(FLT); exp_q.push_back(FLT);
    repeat (17) step(1'b0);
    do_clr("clr_clears_fault");

    begin_test("fetch_after_fault", IR_ADD);
    exp_q.push_back(F0); exp_q.push_back(F1);
    repeat (2) step(1'b1);

    check_int("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
